// File: rtl/centroid_chunk_splitter_if.sv
// Handshake bundle for the centroid chunk splitter: run control, cacheline
// input stream and chunk output stream.
interface centroid_chunk_splitter_if #(
  parameter int unsigned CL_WIDTH         = 512,
  parameter int unsigned ELEM_WIDTH       = 32,
  parameter int unsigned NUM_BANK         = 4,
  parameter int unsigned MAX_CLUSTER_BITS = 8,
  parameter int unsigned MAX_DIM_BITS     = 16
);
  logic                           start;
  logic [MAX_CLUSTER_BITS:0]      num_cluster;
  logic [MAX_DIM_BITS:0]          data_dim;
  logic [CL_WIDTH-1:0]            cl_in;
  logic                           cl_in_valid;
  logic                           cl_in_ready;
  logic [NUM_BANK*ELEM_WIDTH-1:0] chunk_out;
  logic [NUM_BANK-1:0]            chunk_mask;
  logic [MAX_CLUSTER_BITS:0]      chunk_cluster_idx;
  logic                           chunk_valid;
  logic                           chunk_ready;
  logic                           chunk_last_one;
  logic                           chunk_last_all;
  logic                           busy;
  logic                           done;

  // Producer / consumer side (testbench or surrounding system).
  modport master (
    output start, num_cluster, data_dim, cl_in, cl_in_valid, chunk_ready,
    input  cl_in_ready, chunk_out, chunk_mask, chunk_cluster_idx, chunk_valid,
    input  chunk_last_one, chunk_last_all, busy, done
  );

  // Splitter side.
  modport slave (
    input  start, num_cluster, data_dim, cl_in, cl_in_valid, chunk_ready,
    output cl_in_ready, chunk_out, chunk_mask, chunk_cluster_idx, chunk_valid,
    output chunk_last_one, chunk_last_all, busy, done
  );
endinterface

// File: rtl/centroid_chunk_splitter.sv
// Buffers centroid cachelines in a FIFO and slices them into NUM_BANK-element
// chunks, tagging each with its cluster index and masking the tail chunk of
// each centroid when data_dim is not a multiple of NUM_BANK.
module centroid_chunk_splitter #(
  parameter int unsigned CL_WIDTH         = 512,
  parameter int unsigned ELEM_WIDTH       = 32,
  parameter int unsigned NUM_BANK         = 4,
  parameter int unsigned FIFO_DEPTH_BITS  = 6,
  parameter int unsigned MAX_CLUSTER_BITS = 8,
  parameter int unsigned MAX_DIM_BITS     = 16
) (
  input logic                      clk,
  input logic                      rst_n,
  centroid_chunk_splitter_if.slave bus
);
  localparam int unsigned ChunkW   = NUM_BANK * ELEM_WIDTH;
  localparam int unsigned Split    = CL_WIDTH / ChunkW;
  localparam int unsigned SelW     = (Split > 1) ? $clog2(Split) : 1;
  localparam int unsigned BankBits = $clog2(NUM_BANK);
  localparam int unsigned Depth    = 1 << FIFO_DEPTH_BITS;
  localparam int unsigned CluW     = MAX_CLUSTER_BITS + 1;
  localparam int unsigned DimW     = MAX_DIM_BITS + 1;
  localparam int unsigned TotW     = CluW + DimW;
  localparam logic [SelW-1:0] SelMax = SelW'(Split - 1);

  typedef enum logic [1:0] {StIdle, StSetup, StRun} state_e;

  // FIFO: memory plus a registered head line. cnt_q counts both, so the
  // visible capacity is exactly Depth lines.
  logic [CL_WIDTH-1:0]      mem_q [Depth];
  logic [FIFO_DEPTH_BITS:0] wr_ptr_q, rd_ptr_q, cnt_q;
  logic [CL_WIDTH-1:0]      hd_q;
  logic                     hd_valid_q;
  logic                     full, mem_nonempty, wr_en, hd_fill, pop;

  state_e              state_q;
  logic [CluW-1:0]     ncl_q, cluster_q;
  logic [DimW-1:0]     dim_q, cpc_q, dim_cnt_q;
  logic [TotW-1:0]     total_q, sent_cnt_q;
  logic [NUM_BANK-1:0] tail_mask_q;
  logic [SelW-1:0]     sel_q;
  logic                all_loaded_q;

  logic [ChunkW-1:0]   chunk_q;
  logic [NUM_BANK-1:0] mask_q;
  logic [CluW-1:0]     idx_q;
  logic                valid_q, last_one_q, last_all_q, done_q;

  logic [DimW:0]       dim_round;
  logic [DimW-1:0]     cpc_calc, dim_rem;
  logic [TotW-1:0]     total_calc;
  logic [NUM_BANK-1:0] tail_calc, lane_mask;
  logic [ChunkW-1:0]   slice, masked_slice;
  logic                load, is_last_one, is_last_all;

  assign full         = (cnt_q == (FIFO_DEPTH_BITS + 1)'(Depth));
  assign mem_nonempty = (wr_ptr_q != rd_ptr_q);
  assign wr_en        = bus.cl_in_valid & ~full;
  assign is_last_one  = (dim_cnt_q == cpc_q - DimW'(1));
  assign is_last_all  = (sent_cnt_q == total_q - TotW'(1));
  // all_loaded_q stops a stray load while the final chunk waits for accept.
  assign load         = (state_q == StRun) & hd_valid_q & ~all_loaded_q &
                        (~valid_q | bus.chunk_ready);
  assign pop          = load & (is_last_all | (sel_q == SelMax));
  assign hd_fill      = mem_nonempty & (~hd_valid_q | pop);

  // Run geometry from the latched configuration, and lane masking of the slice.
  always_comb begin
    dim_round    = {1'b0, dim_q} + (DimW + 1)'(NUM_BANK - 1);
    cpc_calc     = DimW'(dim_round >> BankBits);
    total_calc   = TotW'(ncl_q) * TotW'(cpc_calc);
    dim_rem      = dim_q & DimW'(NUM_BANK - 1);
    tail_calc    = '0;
    for (int i = 0; i < NUM_BANK; i++) begin
      tail_calc[i] = (dim_rem == '0) || (DimW'(i) < dim_rem);
    end
    lane_mask    = is_last_one ? tail_mask_q : '1;
    slice        = hd_q[int'(sel_q) * ChunkW +: ChunkW];
    masked_slice = '0;
    for (int i = 0; i < NUM_BANK; i++) begin
      masked_slice[i*ELEM_WIDTH +: ELEM_WIDTH] =
          lane_mask[i] ? slice[i*ELEM_WIDTH +: ELEM_WIDTH] : '0;
    end
  end

  // FIFO storage; contents need no reset because the pointers gate them.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[FIFO_DEPTH_BITS-1:0]] <= bus.cl_in;
  end

  // FIFO pointers, occupancy and head-line register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      hd_q       <= '0;
      hd_valid_q <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (hd_fill) begin
        hd_q       <= mem_q[rd_ptr_q[FIFO_DEPTH_BITS-1:0]];
        hd_valid_q <= 1'b1;
        rd_ptr_q   <= rd_ptr_q + 1'b1;
      end else if (pop) begin
        hd_valid_q <= 1'b0;
      end
      if (wr_en && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (!wr_en && pop) cnt_q <= cnt_q - 1'b1;
    end
  end

  // Run FSM, chunk counters and the registered output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      ncl_q        <= '0;
      dim_q        <= '0;
      cpc_q        <= '0;
      total_q      <= '0;
      tail_mask_q  <= '0;
      sel_q        <= '0;
      dim_cnt_q    <= '0;
      cluster_q    <= '0;
      sent_cnt_q   <= '0;
      all_loaded_q <= 1'b0;
      chunk_q      <= '0;
      mask_q       <= '0;
      idx_q        <= '0;
      valid_q      <= 1'b0;
      last_one_q   <= 1'b0;
      last_all_q   <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            ncl_q   <= bus.num_cluster;
            dim_q   <= bus.data_dim;
            state_q <= StSetup;
          end
        end
        StSetup: begin
          cpc_q        <= cpc_calc;
          total_q      <= total_calc;
          tail_mask_q  <= tail_calc;
          sel_q        <= '0;
          dim_cnt_q    <= '0;
          cluster_q    <= '0;
          sent_cnt_q   <= '0;
          all_loaded_q <= 1'b0;
          if (total_calc == '0) begin
            done_q  <= 1'b1;
            state_q <= StIdle;
          end else begin
            state_q <= StRun;
          end
        end
        StRun: begin
          if (valid_q && bus.chunk_ready && last_all_q) begin
            done_q  <= 1'b1;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase

      if (load) begin
        chunk_q    <= masked_slice;
        mask_q     <= lane_mask;
        idx_q      <= cluster_q;
        last_one_q <= is_last_one;
        last_all_q <= is_last_all;
        valid_q    <= 1'b1;
        sel_q      <= (is_last_all || sel_q == SelMax) ? '0 : sel_q + 1'b1;
        sent_cnt_q <= sent_cnt_q + 1'b1;
        if (is_last_one) begin
          dim_cnt_q <= '0;
          cluster_q <= cluster_q + 1'b1;
        end else begin
          dim_cnt_q <= dim_cnt_q + 1'b1;
        end
        if (is_last_all) all_loaded_q <= 1'b1;
      end else if (bus.chunk_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.cl_in_ready       = ~full;
  assign bus.chunk_out         = chunk_q;
  assign bus.chunk_mask        = mask_q;
  assign bus.chunk_cluster_idx = idx_q;
  assign bus.chunk_valid       = valid_q;
  assign bus.chunk_last_one    = last_one_q;
  assign bus.chunk_last_all    = last_all_q;
  assign bus.busy              = (state_q != StIdle);
  assign bus.done              = done_q;
endmodule

// File: tb/tb_centroid_chunk_splitter.sv
// Directed bench for centroid_chunk_splitter with a table of expected chunks.
module tb_centroid_chunk_splitter;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  centroid_chunk_splitter_if bus ();
  centroid_chunk_splitter dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  typedef logic [142:0] pk_t;  // {data[127:0], mask[3:0], idx[8:0], last_one, last_all}
  typedef struct {
    int unsigned off; logic [3:0] mask; logic [8:0] idx; logic lo; logic la;
  } vec_t;
  typedef struct {
    int unsigned ncl; int unsigned dim; int unsigned nlines; int unsigned base;
    int unsigned first; int unsigned nvec; bit rnd;
  } run_t;

  vec_t vecs[10];
  run_t runs[3];
  pk_t  exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask

  function automatic pk_t mk(input int unsigned base, input int unsigned off,
                             input logic [3:0] mask, input logic [8:0] idx,
                             input logic lo, input logic la);
    logic [127:0] d;
    d = '0;
    for (int i = 0; i < 4; i++) if (mask[i]) d[i*32 +: 32] = base + off + i;
    return {d, mask, idx, lo, la};
  endfunction

  function automatic pk_t dut_pk();
    return {bus.chunk_out, bus.chunk_mask, bus.chunk_cluster_idx,
            bus.chunk_last_one, bus.chunk_last_all};
  endfunction

  function automatic logic [511:0] line(input int unsigned base, input int unsigned l);
    logic [511:0] v;
    for (int w = 0; w < 16; w++) v[w*32 +: 32] = base + l * 16 + w;
    return v;
  endfunction

  task automatic start_run(input int unsigned ncl, input int unsigned dim);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.num_cluster = 9'(ncl); bus.data_dim = 17'(dim);
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic write_line(input logic [511:0] d);
    @(posedge clk); #1;
    bus.cl_in_valid = 1'b1; bus.cl_in = d;
    @(posedge clk); #1;
    bus.cl_in_valid = 1'b0;
  endtask

  // Accept n chunks, comparing each against exp_q and checking hold-while-stalled.
  task automatic collect(input int n, input bit rnd, input int budget, input string name);
    int  got = 0;
    int  cyc = 0;
    bit  stall = 0;
    pk_t snap = '0;
    while (got < n && cyc < budget) begin
      @(posedge clk); #1;
      bus.chunk_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      cyc++;
      if (stall) chk({name, "_hold"}, {bus.chunk_valid, dut_pk()}, {1'b1, snap});
      if (bus.chunk_valid && bus.chunk_ready) begin
        chk($sformatf("%s_chunk%0d", name, got), dut_pk(), exp_q.pop_front());
        got++;
        stall = 0;
      end else begin
        stall = bus.chunk_valid;
        snap  = dut_pk();
      end
    end
    if (got < n) begin
      checks++; errors++;
      $display("FAIL %s_timeout got %0d chunks exp %0d", name, got, n);
    end
  endtask

  // Called at the negedge of the final handshake: done must follow for exactly one cycle.
  task automatic chk_done(input string name);
    @(negedge clk);
    chk({name, "_done"}, {bus.done, bus.busy, bus.chunk_valid}, 3'b100);
    @(negedge clk);
    chk({name, "_done_low"}, bus.done, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{0,  4'hF, 9'd0, 1'b0, 1'b0};
    vecs[1] = '{4,  4'hF, 9'd0, 1'b1, 1'b0};
    vecs[2] = '{8,  4'hF, 9'd1, 1'b0, 1'b0};
    vecs[3] = '{12, 4'hF, 9'd1, 1'b1, 1'b1};
    vecs[4] = '{0,  4'hF, 9'd0, 1'b0, 1'b0};
    vecs[5] = '{4,  4'h3, 9'd0, 1'b1, 1'b0};
    vecs[6] = '{8,  4'hF, 9'd1, 1'b0, 1'b0};
    vecs[7] = '{12, 4'h3, 9'd1, 1'b1, 1'b0};
    vecs[8] = '{16, 4'hF, 9'd2, 1'b0, 1'b0};
    vecs[9] = '{20, 4'h3, 9'd2, 1'b1, 1'b1};
    runs[0] = '{2, 8, 1, 32'h100, 0, 4, 1'b0};
    runs[1] = '{3, 6, 2, 32'h200, 4, 6, 1'b0};
    runs[2] = '{2, 8, 1, 32'h300, 0, 4, 1'b1};

    bus.start = 1'b0; bus.num_cluster = '0; bus.data_dim = '0;
    bus.cl_in = '0; bus.cl_in_valid = 1'b0; bus.chunk_ready = 1'b0;

    // Reset state
    #2 rst_n = 1'b0;
    #10;
    chk("reset_outputs", {bus.chunk_valid, dut_pk(), bus.busy, bus.done}, '0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("reset_ready", {bus.cl_in_ready, bus.busy}, 2'b10);

    // Table-driven runs: plain, tail-masked, and random backpressure
    for (int r = 0; r < 3; r++) begin
      exp_q.delete();
      for (int v = 0; v < int'(runs[r].nvec); v++) begin
        vec_t tv;
        tv = vecs[runs[r].first + v];
        exp_q.push_back(mk(runs[r].base, tv.off, tv.mask, tv.idx, tv.lo, tv.la));
      end
      for (int l = 0; l < int'(runs[r].nlines); l++) write_line(line(runs[r].base, l));
      start_run(runs[r].ncl, runs[r].dim);
      collect(int'(runs[r].nvec), runs[r].rnd, 500, $sformatf("run%0d", r));
      chk_done($sformatf("run%0d", r));
    end

    // Empty runs must not pop the prefetched line
    write_line(line(32'h400, 0));
    start_run(0, 8);
    @(negedge clk); chk("zero_ncl_setup", {bus.done, bus.busy, bus.chunk_valid}, 3'b010);
    @(negedge clk); chk("zero_ncl_done", {bus.done, bus.busy, bus.chunk_valid}, 3'b100);
    start_run(2, 0);
    @(negedge clk); chk("zero_dim_setup", {bus.done, bus.busy, bus.chunk_valid}, 3'b010);
    @(negedge clk); chk("zero_dim_done", {bus.done, bus.busy, bus.chunk_valid}, 3'b100);
    exp_q.delete();
    exp_q.push_back(mk(32'h400, 0, 4'hF, 9'd0, 1'b1, 1'b1));
    start_run(1, 4);
    collect(1, 1'b0, 100, "after_zero");
    chk_done("after_zero");

    // Fill past FIFO depth while idle, then drain all 64 lines in order
    for (int i = 0; i < 66; i++) begin
      @(posedge clk); #1;
      bus.cl_in_valid = 1'b1; bus.cl_in = line(32'h5000, i);
      @(negedge clk);
      chk($sformatf("fill_ready%0d", i), bus.cl_in_ready, (i < 64) ? 1'b1 : 1'b0);
    end
    @(posedge clk); #1; bus.cl_in_valid = 1'b0;
    exp_q.delete();
    for (int k = 0; k < 256; k++)
      exp_q.push_back(mk(32'h5000, k * 4, 4'hF, 9'(k / 4), (k % 4) == 3, k == 255));
    start_run(64, 16);
    collect(256, 1'b0, 2000, "full");
    chk_done("full");

    // Reset in the middle of a run, then a clean run
    exp_q.delete();
    for (int k = 0; k < 8; k++)
      exp_q.push_back(mk(32'h600, k * 4, 4'hF, 9'(k / 4), (k % 4) == 3, k == 7));
    write_line(line(32'h600, 0));
    write_line(line(32'h600, 1));
    start_run(2, 16);
    collect(3, 1'b0, 100, "pre_rst");
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_outputs", {bus.chunk_valid, dut_pk(), bus.busy, bus.done}, '0);
    chk("mid_rst_ready", bus.cl_in_ready, 1'b1);
    @(negedge clk); rst_n = 1'b1;
    exp_q.delete();
    for (int v = 0; v < 4; v++)
      exp_q.push_back(mk(32'h700, vecs[v].off, vecs[v].mask, vecs[v].idx, vecs[v].lo,
                         vecs[v].la));
    write_line(line(32'h700, 0));
    start_run(2, 8);
    collect(4, 1'b0, 100, "post_rst");
    chk_done("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
